// File: rtl/packed_signed_accum.sv
// Frame accumulator for packed signed bytes {lo[3:0], hi[3:0]}: sums the sign-extended
// bytes and counts negative ones over FRAME_LEN bytes, then offers the result on valid/ready.
module packed_signed_accum #(
   parameter  int FRAME_LEN = 4,
   parameter  int ACC_W     = 12,
   localparam int CNT_W     = $clog2(FRAME_LEN + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [7:0]              in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [ACC_W-1:0]        out_sum,
   output logic [CNT_W-1:0]        out_neg_cnt,
   output logic                    ERROR
);

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t             state_reg;
   logic [CNT_W-1:0]   count_reg;
   logic [CNT_W-1:0]   neg_cnt_reg;
   logic [ACC_W-1:0]   sum_reg;
   logic [ACC_W-1:0]   out_sum_reg;
   logic [CNT_W-1:0]   out_neg_cnt_reg;
   logic               in_ready_reg;
   logic               out_valid_reg;
   logic               error_reg;

   // lo is the first struct member, so it lands in the upper nibble and carries the sign.
   logic [3:0]         lo_nib;
   logic [3:0]         hi_nib;
   logic               byte_neg;
   logic [ACC_W-1:0]   byte_ext;

   assign lo_nib   = in_data[7:4];
   assign hi_nib   = in_data[3:0];
   assign byte_neg = lo_nib[3];

   genvar gi;
   generate
      for (gi = 0; gi < ACC_W; gi = gi + 1) begin : g_sext
         if (gi < 4) begin : g_hi
            assign byte_ext[gi] = hi_nib[gi];
         end else if (gi < 8) begin : g_lo
            assign byte_ext[gi] = lo_nib[gi-4];
         end else begin : g_sign
            assign byte_ext[gi] = lo_nib[3];
         end
      end
   endgenerate

   logic [ACC_W-1:0]   sum_next;
   logic [CNT_W-1:0]   neg_cnt_next;
   logic [CNT_W-1:0]   count_next;
   logic               add_ovf;
   logic               accept;
   logic               last_byte;

   assign sum_next     = sum_reg + byte_ext;
   assign neg_cnt_next = neg_cnt_reg + CNT_W'(byte_neg);
   assign count_next   = count_reg + CNT_W'(1);
   // Overflow only when both addends agree in sign and the wrapped result disagrees.
   assign add_ovf      = (sum_reg[ACC_W-1] == byte_ext[ACC_W-1]) &&
                         (sum_next[ACC_W-1] != sum_reg[ACC_W-1]);
   assign accept       = in_valid & in_ready_reg;
   assign last_byte    = (count_reg == CNT_W'(FRAME_LEN - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg       <= ACCUM;
         count_reg       <= '0;
         neg_cnt_reg     <= '0;
         sum_reg         <= '0;
         out_sum_reg     <= '0;
         out_neg_cnt_reg <= '0;
         in_ready_reg    <= 1'b1;
         out_valid_reg   <= 1'b0;
         error_reg       <= 1'b0;
      end else begin
         case (state_reg)
            ACCUM: begin
               if (accept) begin
                  sum_reg     <= sum_next;
                  neg_cnt_reg <= neg_cnt_next;
                  count_reg   <= count_next;
                  if (add_ovf) begin
                     error_reg <= 1'b1;
                  end
                  if (last_byte) begin
                     state_reg       <= HOLD;
                     in_ready_reg    <= 1'b0;
                     out_valid_reg   <= 1'b1;
                     out_sum_reg     <= sum_next;
                     out_neg_cnt_reg <= neg_cnt_next;
                  end
               end
            end
            HOLD: begin
               // Input stays blocked during the handshake cycle; a waiting byte goes in next cycle.
               if (out_ready) begin
                  state_reg     <= ACCUM;
                  sum_reg       <= '0;
                  neg_cnt_reg   <= '0;
                  count_reg     <= '0;
                  in_ready_reg  <= 1'b1;
                  out_valid_reg <= 1'b0;
               end
            end
            default: begin
               state_reg     <= ACCUM;
               in_ready_reg  <= 1'b1;
               out_valid_reg <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready    = in_ready_reg;
   assign out_valid   = out_valid_reg;
   assign out_sum     = out_sum_reg;
   assign out_neg_cnt = out_neg_cnt_reg;
   assign ERROR       = error_reg;

endmodule

// File: tb/tb_packed_signed_accum.sv
// Directed bench for packed_signed_accum: default, narrow-accumulator and single-byte-frame builds.
module tb_packed_signed_accum;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_error;
   logic [7:0]  a_in_data;
   logic [11:0] a_out_sum;
   logic [2:0]  a_out_neg_cnt;

   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_error;
   logic [7:0]  b_in_data;
   logic [8:0]  b_out_sum;
   logic [2:0]  b_out_neg_cnt;

   logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_error;
   logic [7:0]  c_in_data;
   logic [11:0] c_out_sum;
   logic [0:0]  c_out_neg_cnt;

   packed_signed_accum #(.FRAME_LEN(4), .ACC_W(12)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_sum(a_out_sum), .out_neg_cnt(a_out_neg_cnt), .ERROR(a_error));

   packed_signed_accum #(.FRAME_LEN(4), .ACC_W(9)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_sum(b_out_sum), .out_neg_cnt(b_out_neg_cnt), .ERROR(b_error));

   packed_signed_accum #(.FRAME_LEN(1), .ACC_W(12)) dut_c (
      .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
      .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
      .out_sum(c_out_sum), .out_neg_cnt(c_out_neg_cnt), .ERROR(c_error));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      if (obs !== exp) begin
         failures = failures + 1;
         $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %s value=0x%0h", tag, obs);
      end
   endtask

   // Present one byte for a single cycle; inputs change only at the falling edge.
   task automatic push(input int sel, input logic [7:0] d);
      case (sel)
         0: begin a_in_valid = 1'b1; a_in_data = d; end
         1: begin b_in_valid = 1'b1; b_in_data = d; end
         default: begin c_in_valid = 1'b1; c_in_data = d; end
      endcase
      @(negedge clk);
      a_in_valid = 1'b0;
      b_in_valid = 1'b0;
      c_in_valid = 1'b0;
   endtask

   task automatic release_out(input int sel);
      case (sel)
         0: a_out_ready = 1'b1;
         1: b_out_ready = 1'b1;
         default: c_out_ready = 1'b1;
      endcase
      @(negedge clk);
      a_out_ready = 1'b0;
      b_out_ready = 1'b0;
      c_out_ready = 1'b0;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst_n = 1'b0;
      a_in_valid = 0; a_in_data = 0; a_out_ready = 0;
      b_in_valid = 0; b_in_data = 0; b_out_ready = 0;
      c_in_valid = 0; c_in_data = 0; c_out_ready = 0;
      repeat (2) @(negedge clk);

      check("rst_out_valid", 32'(a_out_valid), 32'd0);
      check("rst_in_ready", 32'(a_in_ready), 32'd1);
      check("rst_out_sum", 32'(a_out_sum), 32'd0);
      check("rst_neg_cnt", 32'(a_out_neg_cnt), 32'd0);
      check("rst_error", 32'(a_error), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // 200 = 0xC8 = -56; four of them = -224.
      for (int i = 0; i < 4; i++) push(0, 8'd200);
      check("f200_out_valid", 32'(a_out_valid), 32'd1);
      check("f200_sum", 32'(a_out_sum), 32'hF20);
      check("f200_neg_cnt", 32'(a_out_neg_cnt), 32'd4);
      check("f200_error", 32'(a_error), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("hold_out_valid", 32'(a_out_valid), 32'd1);
         check("hold_in_ready", 32'(a_in_ready), 32'd0);
         check("hold_sum_stable", 32'(a_out_sum), 32'hF20);
      end
      release_out(0);
      check("rel_out_valid", 32'(a_out_valid), 32'd0);
      check("rel_in_ready", 32'(a_in_ready), 32'd1);

      // Partial frame discarded by a mid-frame reset.
      push(0, 8'd9);
      push(0, 8'd9);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      push(0, 8'd1);
      push(0, 8'd2);
      push(0, 8'd3);
      check("mid_rst_not_done", 32'(a_out_valid), 32'd0);
      push(0, 8'd4);
      check("mid_rst_valid", 32'(a_out_valid), 32'd1);
      check("mid_rst_sum", 32'(a_out_sum), 32'd10);
      check("mid_rst_neg", 32'(a_out_neg_cnt), 32'd0);
      release_out(0);

      // Byte offered during the release cycle must wait one cycle.
      for (int i = 0; i < 4; i++) push(0, 8'd5);
      check("f5_sum", 32'(a_out_sum), 32'd20);
      a_in_valid = 1'b1;
      a_in_data = 8'd7;
      a_out_ready = 1'b1;
      @(negedge clk);
      a_out_ready = 1'b0;
      check("same_cyc_in_ready", 32'(a_in_ready), 32'd1);
      check("same_cyc_out_valid", 32'(a_out_valid), 32'd0);
      @(negedge clk);
      a_in_valid = 1'b0;
      push(0, 8'd1);
      push(0, 8'd1);
      check("cnt1_not_done", 32'(a_out_valid), 32'd0);
      push(0, 8'd1);
      check("cnt1_done", 32'(a_out_valid), 32'd1);
      check("cnt1_sum", 32'(a_out_sum), 32'd10);
      release_out(0);

      // -128 + 127 - 1 + 1 with idle cycles in between.
      push(0, 8'h80);
      @(negedge clk);
      push(0, 8'h7F);
      repeat (2) @(negedge clk);
      push(0, 8'hFF);
      @(negedge clk);
      check("bub_not_done", 32'(a_out_valid), 32'd0);
      push(0, 8'h01);
      check("bub_valid", 32'(a_out_valid), 32'd1);
      check("bub_sum", 32'(a_out_sum), 32'hFFF);
      check("bub_neg", 32'(a_out_neg_cnt), 32'd2);
      check("bub_error", 32'(a_error), 32'd0);
      release_out(0);

      // 9-bit accumulator: 381 wraps to -131 and flags overflow.
      push(1, 8'd127);
      push(1, 8'd127);
      check("ovf_b_pre_err", 32'(b_error), 32'd0);
      push(1, 8'd127);
      push(1, 8'd0);
      check("ovf_b_valid", 32'(b_out_valid), 32'd1);
      check("ovf_b_sum", 32'(b_out_sum), 32'h17D);
      check("ovf_b_error", 32'(b_error), 32'd1);
      release_out(1);
      for (int i = 0; i < 4; i++) push(1, 8'd1);
      check("ovf_b_clean_sum", 32'(b_out_sum), 32'd4);
      check("ovf_b_sticky", 32'(b_error), 32'd1);
      release_out(1);

      // Single-byte frames.
      push(2, 8'hF0);
      check("f1_valid", 32'(c_out_valid), 32'd1);
      check("f1_sum", 32'(c_out_sum), 32'hFF0);
      check("f1_neg", 32'(c_out_neg_cnt), 32'd1);
      release_out(2);
      push(2, 8'h05);
      check("f1b_sum", 32'(c_out_sum), 32'd5);
      check("f1b_neg", 32'(c_out_neg_cnt), 32'd0);
      release_out(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
